// File: rtl/branch_resolve.sv
// Tracks in-flight predicted conditional branches and resolves them in order,
// producing predictor updates and mispredict flush/redirect pulses.
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int PCW   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pred_valid,
  input  logic                         pred_guess,
  input  logic [PCW-1:0]               pred_alt_pc,
  output logic                         pred_ready,
  input  logic                         res_valid,
  input  logic                         res_taken,
  output logic                         upd_en,
  output logic                         upd_branch,
  output logic                         flush,
  output logic [PCW-1:0]               redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf_err,
  output logic                         unf_err,
  output logic                         dbg_state
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH+1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic RUN   = 1'b0;
  localparam logic FLUSH = 1'b1;

  logic            guess_mem [DEPTH];
  logic [PCW-1:0]  alt_mem   [DEPTH];

  logic            state_q, state_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            upd_en_q, upd_en_d, upd_branch_q, upd_branch_d;
  logic            flush_q, flush_d;
  logic [PCW-1:0]  redirect_q, redirect_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;

  logic            head_guess;
  logic [PCW-1:0]  head_alt;
  logic            pop, mispredict, push;

  // Handshake: a push is taken on a rising edge when pred_valid && pred_ready;
  // a resolve is taken when res_valid && count != 0 (there is no res_ready).
  assign pred_ready = (state_q == RUN) && (count_q != FULL);

  always_comb begin
    head_guess = guess_mem[rd_ptr_q];
    head_alt   = alt_mem[rd_ptr_q];
    pop        = res_valid && (count_q != '0);
    mispredict = pop && (res_taken != head_guess);
    // A push in the same cycle as a mispredict is on the wrong path.
    push       = pred_valid && pred_ready && !mispredict;

    state_d      = mispredict ? FLUSH : RUN;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    upd_en_d     = pop;
    upd_branch_d = pop ? res_taken : 1'b0;
    flush_d      = mispredict;
    redirect_d   = mispredict ? head_alt : redirect_q;
    ovf_d        = ovf_q | (pred_valid && (state_q == RUN) && (count_q == FULL));
    unf_d        = unf_q | (res_valid && (count_q == '0));

    if (mispredict) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      guess_mem[wr_ptr_q] <= pred_guess;
      alt_mem[wr_ptr_q]   <= pred_alt_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      upd_en_q     <= 1'b0;
      upd_branch_q <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      upd_en_q     <= upd_en_d;
      upd_branch_q <= upd_branch_d;
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign upd_en      = upd_en_q;
  assign upd_branch  = upd_branch_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign count       = count_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: in-order resolve, mispredict flush,
// overflow/underflow stickiness, pointer wrap and asynchronous reset.
module tb_branch_resolve;

  localparam int DEPTH = 4;
  localparam int PCW   = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            pred_valid, pred_guess, res_valid, res_taken;
  logic [PCW-1:0]  pred_alt_pc;
  logic            pred_ready, upd_en, upd_branch, flush, ovf_err, unf_err, dbg_state;
  logic [PCW-1:0]  redirect_pc;
  logic [2:0]      count;

  int tests_run    = 0;
  int tests_failed = 0;

  branch_resolve #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_guess(pred_guess), .pred_alt_pc(pred_alt_pc),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_en(upd_en), .upd_branch(upd_branch),
    .flush(flush), .redirect_pc(redirect_pc), .count(count),
    .ovf_err(ovf_err), .unf_err(unf_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pred_valid = 1'b0; pred_guess = 1'b0; pred_alt_pc = '0;
    res_valid = 1'b0; res_taken = 1'b0;
  endtask

  task automatic do_push(input logic g, input logic [PCW-1:0] alt);
    pred_valid = 1'b1; pred_guess = g; pred_alt_pc = alt;
    cycle();
    drive_idle();
  endtask

  task automatic do_resolve(input logic t);
    res_valid = 1'b1; res_taken = t;
    cycle();
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    #2;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (upd_en !== 1'b0 || flush !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: upd_en=%b flush=%b expected 0 0", upd_en, flush); end
    tests_run++; if (redirect_pc !== 64'h0) begin tests_failed++; $display("FAIL reset_redirect: got %h expected 0", redirect_pc); end
    tests_run++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin tests_failed++; $display("FAIL reset_errs: ovf=%b unf=%b expected 0 0", ovf_err, unf_err); end
    tests_run++; if (pred_ready !== 1'b1 || dbg_state !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_state: ready=%b state=%b expected 1 0", pred_ready, dbg_state); end
  endtask

  task automatic test_correct();
    logic [2:0] exp_cnt [3];
    logic       outc [3];
    exp_cnt[0] = 3'd2; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd0;
    outc[0] = 1'b1; outc[1] = 1'b0; outc[2] = 1'b1;
    do_push(1'b1, 64'h100);
    do_push(1'b0, 64'h200);
    do_push(1'b1, 64'h300);
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL correct_fill: count %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      do_resolve(outc[i]);
      tests_run++; if (upd_en !== 1'b1 || upd_branch !== outc[i]) begin tests_failed++; $display("FAIL correct_upd%0d: en=%b br=%b expected 1 %b", i, upd_en, upd_branch, outc[i]); end
      tests_run++; if (flush !== 1'b0 || count !== exp_cnt[i]) begin tests_failed++; $display("FAIL correct_pop%0d: flush=%b count=%0d expected 0 %0d", i, flush, count, exp_cnt[i]); end
    end
    cycle();
    tests_run++; if (upd_en !== 1'b0 || flush !== 1'b0) begin tests_failed++; $display("FAIL correct_idle: en=%b flush=%b expected 0 0", upd_en, flush); end
  endtask

  task automatic test_mispredict();
    do_push(1'b1, 64'h40);
    do_push(1'b0, 64'h80);
    do_resolve(1'b0);
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 64'h40) begin tests_failed++; $display("FAIL mis_flush: flush=%b pc=%h expected 1 40", flush, redirect_pc); end
    tests_run++; if (count !== 3'd0 || upd_en !== 1'b1 || upd_branch !== 1'b0) begin tests_failed++; $display("FAIL mis_state: count=%0d en=%b br=%b expected 0 1 0", count, upd_en, upd_branch); end
    tests_run++; if (pred_ready !== 1'b0 || dbg_state !== 1'b1) begin tests_failed++; $display("FAIL mis_fsm: ready=%b state=%b expected 0 1", pred_ready, dbg_state); end
    // push presented during the FLUSH cycle must be ignored silently
    do_push(1'b1, 64'hDEAD);
    tests_run++; if (count !== 3'd0 || ovf_err !== 1'b0) begin tests_failed++; $display("FAIL flush_push: count=%0d ovf=%b expected 0 0", count, ovf_err); end
    tests_run++; if (flush !== 1'b0 || redirect_pc !== 64'h40 || pred_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_end: flush=%b pc=%h ready=%b expected 0 40 1", flush, redirect_pc, pred_ready); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) do_push(1'b1, 64'h10 + 64'(i));
    tests_run++; if (count !== 3'd4 || pred_ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_full: count=%0d ready=%b expected 4 0", count, pred_ready); end
    do_push(1'b0, 64'hBAD);
    tests_run++; if (count !== 3'd4 || ovf_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_drop: count=%0d ovf=%b expected 4 1", count, ovf_err); end
    do_resolve(1'b1);
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL ovf_pop: count=%0d expected 3", count); end
    pred_valid = 1'b1; pred_guess = 1'b0; pred_alt_pc = 64'h55;
    res_valid = 1'b1; res_taken = 1'b1;
    cycle();
    drive_idle();
    tests_run++; if (count !== 3'd3 || upd_en !== 1'b1 || flush !== 1'b0) begin tests_failed++; $display("FAIL push_pop: count=%0d en=%b flush=%b expected 3 1 0", count, upd_en, flush); end
    do_resolve(1'b1);
    do_resolve(1'b1);
    tests_run++; if (count !== 3'd1 || flush !== 1'b0) begin tests_failed++; $display("FAIL wrap_pop: count=%0d flush=%b expected 1 0", count, flush); end
    // last entry is the wrapped push with guess 0: resolving taken mispredicts
    do_resolve(1'b1);
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 64'h55) begin tests_failed++; $display("FAIL wrap_redirect: flush=%b pc=%h expected 1 55", flush, redirect_pc); end
    tests_run++; if (ovf_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
    cycle();
  endtask

  task automatic test_underflow();
    do_resolve(1'b1);
    tests_run++; if (unf_err !== 1'b1 || upd_en !== 1'b0) begin tests_failed++; $display("FAIL unf_set: unf=%b en=%b expected 1 0", unf_err, upd_en); end
    cycle();
    tests_run++; if (unf_err !== 1'b1 || count !== 3'd0) begin tests_failed++; $display("FAIL unf_sticky: unf=%b count=%0d expected 1 0", unf_err, count); end
  endtask

  task automatic test_mispred_push_reset();
    do_push(1'b1, 64'h77);
    pred_valid = 1'b1; pred_guess = 1'b0; pred_alt_pc = 64'h99;
    res_valid = 1'b1; res_taken = 1'b0;
    cycle();
    drive_idle();
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 64'h77 || count !== 3'd0) begin tests_failed++; $display("FAIL mis_push: flush=%b pc=%h count=%0d expected 1 77 0", flush, redirect_pc, count); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (flush !== 1'b0 || upd_en !== 1'b0 || upd_branch !== 1'b0) begin tests_failed++; $display("FAIL async_pulses: flush=%b en=%b br=%b expected 0 0 0", flush, upd_en, upd_branch); end
    tests_run++; if (redirect_pc !== 64'h0 || ovf_err !== 1'b0 || unf_err !== 1'b0 || dbg_state !== 1'b0) begin tests_failed++; $display("FAIL async_regs: pc=%h ovf=%b unf=%b st=%b expected 0 0 0 0", redirect_pc, ovf_err, unf_err, dbg_state); end
    #1;
    reset = 1'b0;
    cycle();
    tests_run++; if (flush !== 1'b0 || upd_en !== 1'b0 || count !== 3'd0 || pred_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset: flush=%b en=%b count=%0d ready=%b expected 0 0 0 1", flush, upd_en, count, pred_ready); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_overflow();
    test_underflow();
    test_mispred_push_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of in-flight predicted branches held (power of two, 2..16).
REQ-002 The module SHALL have parameter PCW, default 64, giving the PC width.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port pred_valid  input  1  fetch pushes one predicted conditional branch this cycle.
REQ-006 The module SHALL have port pred_guess  input  1  predictor guess pushed with the branch (1 = taken).
REQ-007 The module SHALL have port pred_alt_pc  input  PCW  not-chosen path PC (fall-through if guessed taken, target if guessed not taken).
REQ-008 The module SHALL have port pred_ready  output  1  high when count < DEPTH and state is RUN.
REQ-009 The module SHALL have port res_valid  input  1  execute resolves the oldest in-flight branch this cycle.
REQ-010 The module SHALL have port res_taken  input  1  actual outcome of the resolved branch.
REQ-011 The module SHALL have port upd_en  output  1  predictor update strobe, drives the predictor's en.
REQ-012 The module SHALL have port upd_branch  output  1  actual outcome, drives the predictor's branch.
REQ-013 The module SHALL have port flush  output  1  mispredict: squash younger instructions and redirect fetch.
REQ-014 The module SHALL have port redirect_pc  output  PCW  fetch target while flush is high.
REQ-015 The module SHALL have port count  output  clog2(DEPTH+1)  number of in-flight entries.
REQ-016 The module SHALL have port ovf_err and unf_err  output  1 each  sticky errors: push while full, resolve while empty.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries {guess, alt_pc}, with write and read pointers wrapping modulo DEPTH.
REQ-018 The FSM SHALL have two states, RUN and FLUSH: RUN -> FLUSH on an accepted resolve with res_taken != stored guess; FLUSH -> RUN unconditionally after one cycle.
REQ-019 An accepted push SHALL require pred_valid && pred_ready; in RUN with count==DEPTH the push SHALL be dropped and ovf_err set.
REQ-020 An accepted resolve SHALL require res_valid && count>0; with res_valid && count==0 the resolve SHALL be ignored and unf_err set.
REQ-021 An accepted resolve SHALL produce, in the following cycle, upd_en=1 and upd_branch=res_taken for exactly one cycle (1-cycle latency, registered).
REQ-022 A correct resolve SHALL pop one entry, with flush staying 0.
REQ-023 A mispredicting resolve SHALL, in the following cycle, drive flush=1 for one cycle and redirect_pc=the popped entry's alt_pc.
REQ-024 A mispredicting resolve SHALL discard all younger entries (count -> 0, rd_ptr=wr_ptr) on the same edge.
REQ-025 Simultaneous push and correct resolve SHALL both take effect, leaving count unchanged; this SHALL be legal at count==DEPTH only as pop-then-push if pred_ready was high.
REQ-026 Simultaneous push and mispredicting resolve SHALL discard the push (wrong-path).
REQ-027 In FLUSH, pred_valid SHALL be ignored (pred_ready=0) without setting ovf_err; res_valid SHALL be handled per REQ-020.
REQ-028 redirect_pc SHALL hold its last value when flush=0.
REQ-029 upd_en, flush, ovf_err and unf_err SHALL never be X after reset.

Reset
REQ-030 reset=1 SHALL immediately force state=RUN, pointers=0, count=0, upd_en=0, upd_branch=0, flush=0, redirect_pc=0, ovf_err=0 and unf_err=0, regardless of clk.
REQ-031 Reset asserted mid-operation (including during FLUSH) SHALL discard all entries, and no upd_en or flush pulse SHALL follow deassertion.
REQ-032 Only reset SHALL clear the error flags.

Verification
REQ-033 Reset, push guesses 1,0,1 (alt_pc 0x100,0x200,0x300), then resolve taken,not,taken -> count 3->0, upd_en pulses with upd_branch 1,0,1, flush never high.
REQ-034 Push guess=1 alt 0x40, guess=0 alt 0x80; resolve taken=0 -> next cycle flush=1 with redirect_pc=0x40, count=0, upd_branch=0; FLUSH lasts one cycle.
REQ-035 Fill to DEPTH=4, push again -> pred_ready=0, push dropped, ovf_err=1 and stays 1; then a push plus correct resolve at count 3 -> count stays 3, pointers wrap correctly.
REQ-036 res_valid with count=0 -> unf_err=1, no upd_en pulse; push during FLUSH cycle -> ignored, count stays 0, ovf_err unchanged.
REQ-037 Mispredicting resolve with simultaneous push -> push discarded, count=0; reset asserted between clk edges during FLUSH -> flush drops immediately, all outputs at reset values.
